// File: rtl/cpu_exec_ctrl.sv
// Execution controller for the 4-bit CPU core: program memory, run/halt/step FSM,
// PC breakpoint, saturating instruction counter and host write port. Optional IO-watch break: CPU_EXEC_CTRL_IOBRK_EN.
module cpu_exec_ctrl #(
  parameter int PC_W   = 4,
  parameter int INST_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  input  logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic              cpu_en,
  input  logic              bp_valid,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              host_wr_en,
  input  logic [PC_W-1:0]   host_wr_addr,
  input  logic [INST_W-1:0] host_wr_data,
  output logic              host_wr_ack,
  output logic              host_wr_err,
  output logic [1:0]        state,
  output logic [1:0]        brk_cause,
  output logic [CNT_W-1:0]  instr_count
`ifdef CPU_EXEC_CTRL_IOBRK_EN
  ,
  input  logic [3:0]        io_watch
`endif
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam int DEPTH = 2 ** PC_W;

  state_e              state_q, state_d;
  logic                skip_bp_q, skip_bp_d;
  logic [1:0]          brk_cause_q, brk_cause_d;
  logic [CNT_W-1:0]    instr_count_q;
  logic                host_wr_ack_q, host_wr_err_q;
  logic [INST_W-1:0]   mem_q [DEPTH];
  logic                bp_hit, io_hit, stop_now, stopped;

  assign bp_hit   = bp_valid && (pc == bp_addr) && !skip_bp_q;
`ifdef CPU_EXEC_CTRL_IOBRK_EN
  logic [3:0] io_prev_q;
  assign io_hit = (state_q == ST_RUN) && (io_watch != io_prev_q);
  always_ff @(posedge clk_cpu) begin
    if (reset) io_prev_q <= 4'd0;
    else       io_prev_q <= io_watch;
  end
`else
  assign io_hit = 1'b0;
`endif
  assign stop_now = bp_hit || io_hit;
  assign cpu_en   = ((state_q == ST_RUN) && !stop_now) || (state_q == ST_STEP);
  assign stopped  = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign inst     = mem_q[pc];

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    skip_bp_d   = skip_bp_q;
    brk_cause_d = brk_cause_q;
    unique case (state_q)
      ST_HALT: begin
        if (!halt) begin
          if (step) begin
            state_d = ST_STEP;
          end else if (run) begin
            state_d   = ST_RUN;
            skip_bp_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cpu_en) skip_bp_d = 1'b0;
        if (halt) begin
          state_d = ST_HALT;
        end else if (bp_hit) begin
          state_d     = ST_BREAK;
          brk_cause_d = 2'd1;
        end else if (io_hit) begin
          state_d     = ST_BREAK;
          brk_cause_d = 2'd2;
        end
      end
      ST_STEP: state_d = ST_HALT;
      ST_BREAK: begin
        if (halt) begin
          state_d     = ST_HALT;
          brk_cause_d = 2'd0;
        end else if (step) begin
          state_d     = ST_STEP;
          brk_cause_d = 2'd0;
        end else if (run) begin
          state_d     = ST_RUN;
          skip_bp_d   = 1'b1;
          brk_cause_d = 2'd0;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q       <= ST_HALT;
      skip_bp_q     <= 1'b0;
      brk_cause_q   <= 2'd0;
      instr_count_q <= '0;
      host_wr_ack_q <= 1'b0;
      host_wr_err_q <= 1'b0;
      // NOTE: the program memory is cleared on reset, which keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      skip_bp_q     <= skip_bp_d;
      brk_cause_q   <= brk_cause_d;
      host_wr_ack_q <= host_wr_en && stopped;
      host_wr_err_q <= host_wr_en && !stopped;
      if (host_wr_en && stopped) mem_q[host_wr_addr] <= host_wr_data;
      if (cpu_en && (instr_count_q != {CNT_W{1'b1}}))
        instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign brk_cause   = brk_cause_q;
  assign instr_count = instr_count_q;
  assign host_wr_ack = host_wr_ack_q;
  assign host_wr_err = host_wr_err_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl: a small PC model stands in for the core,
// host write responses go through a scoreboard queue.
module tb_cpu_exec_ctrl;

  logic       clk_cpu = 1'b0;
  logic       reset, run, halt, step;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       cpu_en;
  logic       bp_valid;
  logic [3:0] bp_addr;
  logic       host_wr_en;
  logic [3:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       host_wr_ack, host_wr_err;
  logic [1:0] state, brk_cause;
  logic [7:0] instr_count;
`ifdef CPU_EXEC_CTRL_IOBRK_EN
  logic [3:0] io_watch;
`endif

  logic       pc_load;
  logic [3:0] pc_ld_val;

  typedef struct packed {logic ack; logic err;} wr_resp_t;
  wr_resp_t wr_q[$];

  int checks = 0;
  int passed = 0;

  cpu_exec_ctrl dut (
    .clk_cpu      (clk_cpu),
    .reset        (reset),
    .run          (run),
    .halt         (halt),
    .step         (step),
    .pc           (pc),
    .inst         (inst),
    .cpu_en       (cpu_en),
    .bp_valid     (bp_valid),
    .bp_addr      (bp_addr),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .host_wr_err  (host_wr_err),
    .state        (state),
    .brk_cause    (brk_cause),
    .instr_count  (instr_count)
`ifdef CPU_EXEC_CTRL_IOBRK_EN
    ,
    .io_watch     (io_watch)
`endif
  );

  always #5 clk_cpu = ~clk_cpu;

  // Core stand-in: PC advances on every enabled cycle and wraps naturally.
  always @(posedge clk_cpu) begin
    if (pc_load)     pc <= pc_ld_val;
    else if (cpu_en) pc <= pc + 4'd1;
  end

  task automatic cyc();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr_push(input logic [3:0] a, input logic [7:0] d, input logic ack, input logic err);
    wr_resp_t r;
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    r.ack = ack;
    r.err = err;
    wr_q.push_back(r);
  endtask

  task automatic wr_pop_check(input string tag);
    wr_resp_t r;
    if (wr_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = wr_q.pop_front();
      check({tag, "_ack"}, 32'(host_wr_ack), 32'(r.ack));
      check({tag, "_err"}, 32'(host_wr_err), 32'(r.err));
    end
  endtask

  initial begin
    logic [7:0] prog [4];
    prog[0] = 8'h31; prog[1] = 8'hF0; prog[2] = 8'h00; prog[3] = 8'h00;
    reset = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
    bp_valid = 1'b0; bp_addr = 4'd0;
    host_wr_en = 1'b0; host_wr_addr = 4'd0; host_wr_data = 8'd0;
    pc_load = 1'b1; pc_ld_val = 4'd0;
`ifdef CPU_EXEC_CTRL_IOBRK_EN
    io_watch = 4'd0;
`endif

    // Reset state
    cyc(); cyc();
    reset = 1'b0; pc_load = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_cause", 32'(brk_cause), 32'd0);
    check("rst_ack", 32'(host_wr_ack), 32'd0);
    check("rst_err", 32'(host_wr_err), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);

    // Program load from HALT, back-to-back writes
    for (int i = 0; i < 4; i++) begin
      wr_push(4'(i), prog[i], 1'b1, 1'b0);
      cyc();
      wr_pop_check("prog_wr");
    end
    host_wr_en = 1'b0;
    cyc();
    check("ack_one_cycle", 32'(host_wr_ack), 32'd0);
    pc_load = 1'b1; pc_ld_val = 4'd1;
    cyc();
    pc_load = 1'b0;
    check("inst_pc1", 32'(inst), 32'hF0);

    // Continuous run, halt after 10 enabled cycles
    pc_load = 1'b1; pc_ld_val = 4'd0; run = 1'b1;
    cyc();
    pc_load = 1'b0; run = 1'b0;
    check("run_state", 32'(state), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("run_en", 32'(cpu_en), 32'd1);
      if (i == 9) halt = 1'b1;
      cyc();
    end
    halt = 1'b0;
    check("halt_state", 32'(state), 32'd0);
    check("halt_en", 32'(cpu_en), 32'd0);
    check("halt_count", 32'(instr_count), 32'd10);

    // Breakpoint at pc=3
    bp_valid = 1'b1; bp_addr = 4'd3;
    pc_load = 1'b1; pc_ld_val = 4'd0; run = 1'b1;
    cyc();
    pc_load = 1'b0; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_pre_en", 32'(cpu_en), 32'd1);
      cyc();
    end
    check("bp_pc", 32'(pc), 32'd3);
    check("bp_stall_en", 32'(cpu_en), 32'd0);
    cyc();
    check("bp_state", 32'(state), 32'd3);
    check("bp_cause", 32'(brk_cause), 32'd1);
    check("bp_count", 32'(instr_count), 32'd13);
    check("bp_pc_hold", 32'(pc), 32'd3);

    // Writes are accepted while in BREAK
    wr_push(4'd8, 8'h77, 1'b1, 1'b0);
    cyc();
    host_wr_en = 1'b0;
    wr_pop_check("brk_wr");

    // Resume: the breakpoint instruction executes, no re-break until pc returns to 3
    run = 1'b1;
    cyc();
    run = 1'b0;
    check("resume_state", 32'(state), 32'd1);
    check("resume_cause", 32'(brk_cause), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("resume_en", 32'(cpu_en), 32'd1);
      cyc();
    end
    check("rebreak_en", 32'(cpu_en), 32'd0);
    cyc();
    check("rebreak_state", 32'(state), 32'd3);
    check("rebreak_count", 32'(instr_count), 32'd29);

    // Coincident step+run in BREAK selects STEP
    step = 1'b1; run = 1'b1;
    cyc();
    step = 1'b0; run = 1'b0;
    check("step_state", 32'(state), 32'd2);
    check("step_en", 32'(cpu_en), 32'd1);
    cyc();
    check("step_done_state", 32'(state), 32'd0);
    check("step_done_en", 32'(cpu_en), 32'd0);
    check("step_count", 32'(instr_count), 32'd30);
    check("step_cause", 32'(brk_cause), 32'd0);
    check("step_pc", 32'(pc), 32'd4);

    // Run pulse during STEP is ignored
    step = 1'b1;
    cyc();
    step = 1'b0; run = 1'b1;
    check("step2_state", 32'(state), 32'd2);
    cyc();
    run = 1'b0;
    check("step2_done", 32'(state), 32'd0);
    check("step2_count", 32'(instr_count), 32'd31);

    // halt beats step and run
    halt = 1'b1; step = 1'b1; run = 1'b1;
    cyc();
    halt = 1'b0; step = 1'b0; run = 1'b0;
    check("prio_state", 32'(state), 32'd0);
    check("prio_count", 32'(instr_count), 32'd31);

    // Host write rejected in RUN
    bp_valid = 1'b0;
    run = 1'b1;
    cyc();
    run = 1'b0;
    wr_push(4'd2, 8'hAA, 1'b0, 1'b1);
    cyc();
    host_wr_en = 1'b0;
    wr_pop_check("run_wr");
    pc_load = 1'b1; pc_ld_val = 4'd2;
    cyc();
    pc_load = 1'b0;
    check("mem2_unchanged", 32'(inst), 32'h00);

    // Reset mid-RUN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_count", 32'(instr_count), 32'd0);
    check("mid_rst_en", 32'(cpu_en), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pc_load = 1'b1; pc_ld_val = 4'(i);
      cyc();
      check("mem_cleared", 32'(inst), 32'd0);
    end
    pc_load = 1'b0;

    // Write and run in the same HALT cycle: first fetch sees the new word
    pc_load = 1'b1; pc_ld_val = 4'd0; run = 1'b1;
    wr_push(4'd0, 8'h5A, 1'b1, 1'b0);
    cyc();
    pc_load = 1'b0; run = 1'b0; host_wr_en = 1'b0;
    wr_pop_check("wr_run");
    check("wr_run_state", 32'(state), 32'd1);
    check("wr_run_inst", 32'(inst), 32'h5A);
    check("wr_run_en", 32'(cpu_en), 32'd1);

    // Counter saturation
    repeat (260) cyc();
    check("count_sat", 32'(instr_count), 32'd255);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    check("sat_halt", 32'(state), 32'd0);

`ifdef CPU_EXEC_CTRL_IOBRK_EN
    run = 1'b1;
    cyc();
    run = 1'b0;
    check("io_run_en", 32'(cpu_en), 32'd1);
    io_watch = 4'd5;
    #1;
    check("io_stall_en", 32'(cpu_en), 32'd0);
    cyc();
    check("io_state", 32'(state), 32'd3);
    check("io_cause", 32'(brk_cause), 32'd2);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    check("io_halt_cause", 32'(brk_cause), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
